// File: rtl/mem_port_arbiter_if.sv
// Two-requester access bus plus single-port SRAM strobes for mem_port_arbiter.
// Requesters hold req/we/addr/wdata stable until gnt; slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Data2Mem;
    logic [DATA_W-1:0] ReadDataMem;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadDataMem,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output CEN, WEN, OEN, A, Data2Mem
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadDataMem,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  CEN, WEN, OEN, A, Data2Mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for two requesters onto one SRAM port; write 2 cycles, read 2+READ_LAT.
// No queueing: requests are sampled only in IDLE and a requester waits (req held) until its gnt pulse.
module mem_port_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(READ_LAT);

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              win;
    logic              cmd_we;
    logic [1:0]        cnt;
    logic              take;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take      = 1'b1;
                    pick      = (bus.req0 && bus.req1) ? prio : bus.req1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = cmd_we ? IDLE : RDWAIT;
            RDWAIT:  if (cnt <= 2'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_we    = pick ? bus.we1    : bus.we0;
    assign sel_addr  = pick ? bus.addr1  : bus.addr0;
    assign sel_wdata = pick ? bus.wdata1 : bus.wdata0;

    // Strobes are loaded on the sampling edge so they are valid for exactly the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio         <= 1'b0;
            win          <= 1'b0;
            cmd_we       <= 1'b0;
            cnt          <= 2'd0;
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.rvalid0  <= 1'b0;
            bus.rvalid1  <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
            bus.CEN      <= 1'b1;
            bus.WEN      <= 1'b1;
            bus.OEN      <= 1'b1;
            bus.A        <= '0;
            bus.Data2Mem <= '0;
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.CEN     <= 1'b1;
            bus.WEN     <= 1'b1;
            bus.OEN     <= 1'b1;

            if (take) begin
                win          <= pick;
                prio         <= ~pick;
                cmd_we       <= sel_we;
                bus.gnt0     <= ~pick;
                bus.gnt1     <= pick;
                bus.CEN      <= 1'b0;
                bus.WEN      <= ~sel_we;
                bus.OEN      <= sel_we;
                bus.A        <= sel_addr;
                bus.Data2Mem <= sel_we ? sel_wdata : '0;
            end

            if (state == ACCESS && !cmd_we) cnt <= CNT_LOAD;

            if (state == RDWAIT) begin
                cnt <= cnt - 2'd1;
                if (state_nxt == IDLE) begin
                    if (win) begin
                        bus.rdata1  <= bus.ReadDataMem;
                        bus.rvalid1 <= 1'b1;
                    end else begin
                        bus.rdata0  <= bus.ReadDataMem;
                        bus.rvalid0 <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with READ_LAT=1 and one with READ_LAT=3, each on its own SRAM model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) ia ();
    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) ib ();

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    // Synchronous SRAM models: read data appears after the strobe edge and is held.
    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:127];
    logic [31:0] rd_a = '0;
    logic [31:0] rd_b = '0;
    assign ia.ReadDataMem = rd_a;
    assign ib.ReadDataMem = rd_b;

    always @(posedge clk) begin
        if (!ia.CEN && !ia.WEN) mem_a[ia.A] <= ia.Data2Mem;
        if (!ia.CEN &&  ia.WEN) rd_a <= mem_a[ia.A];
        if (!ib.CEN && !ib.WEN) mem_b[ib.A] <= ib.Data2Mem;
        if (!ib.CEN &&  ib.WEN) rd_b <= mem_b[ib.A];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ia.req0 = 0; ia.req1 = 0; ia.we0 = 0; ia.we1 = 0;
        ia.addr0 = '0; ia.addr1 = '0; ia.wdata0 = '0; ia.wdata1 = '0;
        ib.req0 = 0; ib.req1 = 0; ib.we0 = 0; ib.we1 = 0;
        ib.addr0 = '0; ib.addr1 = '0; ib.wdata0 = '0; ib.wdata1 = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd7);
        chk("rst_A", {25'd0, ia.A}, 32'd0);
        chk("rst_d2m", ia.Data2Mem, 32'd0);
        chk("rst_gnt", {30'd0, ia.gnt0, ia.gnt1}, 32'd0);
        chk("rst_rvalid", {30'd0, ia.rvalid0, ia.rvalid1}, 32'd0);
        chk("rst_rdata0", ia.rdata0, 32'd0);
        chk("rst_rdata1", ia.rdata1, 32'd0);
        rst_n = 1'b1;

        // Write from requester 0
        ia.req0 = 1; ia.we0 = 1; ia.addr0 = 7'h05; ia.wdata0 = 32'hDEADBEEF;
        tick();
        chk("wr_gnt", {30'd0, ia.gnt0, ia.gnt1}, 32'd2);
        chk("wr_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd1);
        chk("wr_A", {25'd0, ia.A}, 32'h05);
        chk("wr_d2m", ia.Data2Mem, 32'hDEADBEEF);
        ia.req0 = 0;
        tick();
        chk("wr_end_gnt", {30'd0, ia.gnt0, ia.gnt1}, 32'd0);
        chk("wr_end_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd7);
        chk("wr_end_A_hold", {25'd0, ia.A}, 32'h05);
        chk("wr_end_d2m_hold", ia.Data2Mem, 32'hDEADBEEF);

        // Read-back by requester 1, READ_LAT=1
        ia.req1 = 1; ia.we1 = 0; ia.addr1 = 7'h05;
        tick();
        chk("rd_gnt", {30'd0, ia.gnt0, ia.gnt1}, 32'd1);
        chk("rd_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd2);
        chk("rd_A", {25'd0, ia.A}, 32'h05);
        chk("rd_d2m_zero", ia.Data2Mem, 32'd0);
        ia.req1 = 0;
        tick();
        chk("rd_wait_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd7);
        chk("rd_wait_rvalid", {30'd0, ia.rvalid0, ia.rvalid1}, 32'd0);
        tick();
        chk("rd_rvalid", {30'd0, ia.rvalid0, ia.rvalid1}, 32'd1);
        chk("rd_rdata1", ia.rdata1, 32'hDEADBEEF);
        tick();
        chk("rd_rvalid_pulse", {30'd0, ia.rvalid0, ia.rvalid1}, 32'd0);
        chk("rd_rdata1_hold", ia.rdata1, 32'hDEADBEEF);

        // Reset, then continuous contention with writes
        rst_n = 1'b0;
        tick();
        chk("rst2_rdata1", ia.rdata1, 32'd0);
        rst_n = 1'b1;
        ia.req0 = 1; ia.we0 = 1; ia.addr0 = 7'h10; ia.wdata0 = 32'h11111111;
        ia.req1 = 1; ia.we1 = 1; ia.addr1 = 7'h20; ia.wdata1 = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("cont_gnt%0d", i), {30'd0, ia.gnt0, ia.gnt1}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk($sformatf("cont_A%0d", i), {25'd0, ia.A}, (i % 2 == 0) ? 32'h10 : 32'h20);
            chk($sformatf("cont_d2m%0d", i), ia.Data2Mem, (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
            tick();
            chk($sformatf("cont_gap%0d", i), {30'd0, ia.gnt0, ia.gnt1}, 32'd0);
        end
        ia.req0 = 0; ia.req1 = 0;
        tick();

        // req1 alone, then both together: requester 0 wins
        ia.req1 = 1; ia.addr1 = 7'h30;
        tick();
        chk("tog_gnt1", {30'd0, ia.gnt0, ia.gnt1}, 32'd1);
        ia.req1 = 0;
        tick();
        ia.req0 = 1; ia.req1 = 1;
        tick();
        chk("tog_both", {30'd0, ia.gnt0, ia.gnt1}, 32'd2);
        ia.req0 = 0;
        tick();
        tick();
        chk("tog_next", {30'd0, ia.gnt0, ia.gnt1}, 32'd1);
        ia.req1 = 0;
        tick();

        // READ_LAT=3: write then read back on the second arbiter
        ib.req0 = 1; ib.we0 = 1; ib.addr0 = 7'h09; ib.wdata0 = 32'hCAFEF00D;
        tick();
        chk("l3_wr_gnt", {30'd0, ib.gnt0, ib.gnt1}, 32'd2);
        ib.req0 = 0; ib.we0 = 0;
        tick();
        ib.req0 = 1;
        tick();
        chk("l3_rd_gnt", {30'd0, ib.gnt0, ib.gnt1}, 32'd2);
        chk("l3_rd_strobes", {29'd0, ib.CEN, ib.WEN, ib.OEN}, 32'd2);
        ib.req0 = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("l3_wait_strobes%0d", k), {29'd0, ib.CEN, ib.WEN, ib.OEN}, 32'd7);
            chk($sformatf("l3_wait_rvalid%0d", k), {30'd0, ib.rvalid0, ib.rvalid1}, 32'd0);
        end
        tick();
        chk("l3_rvalid", {30'd0, ib.rvalid0, ib.rvalid1}, 32'd2);
        chk("l3_rdata0", ib.rdata0, 32'hCAFEF00D);
        chk("l3_strobes_end", {29'd0, ib.CEN, ib.WEN, ib.OEN}, 32'd7);
        tick();

        // Reset during RDWAIT aborts the read
        ia.req0 = 1; ia.we0 = 0; ia.addr0 = 7'h05;
        tick();
        chk("ab_gnt", {30'd0, ia.gnt0, ia.gnt1}, 32'd2);
        ia.req0 = 0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("ab_strobes", {29'd0, ia.CEN, ia.WEN, ia.OEN}, 32'd7);
        chk("ab_rvalid", {30'd0, ia.rvalid0, ia.rvalid1}, 32'd0);
        chk("ab_rdata0", ia.rdata0, 32'd0);
        chk("ab_rdata1", ia.rdata1, 32'd0);
        chk("ab_b_rdata0", ib.rdata0, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ab_late%0d", k), {28'd0, ia.rvalid0, ia.rvalid1, ia.gnt0, ia.gnt1}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 7, word address width; DATA_W, 32, data width; READ_LAT, 1, SRAM read latency in cycles after the strobe cycle, 1..3.
REQ-002 SHALL have ports (name direction width meaning):
  clk  input  1  single clock, all state on rising edge
  rst_n  input  1  reset, synchronous, active-low
  req0/req1  input  1  access request from requester 0 (core) / 1 (loader)
  we0/we1  input  1  1 = write, 0 = read
  addr0/addr1  input  ADDR_W  word address
  wdata0/wdata1  input  DATA_W  write data
  gnt0/gnt1  output  1  one-cycle grant pulse
  rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse
  rdata0/rdata1  output  DATA_W  read data, held until next read completes for that requester
  CEN  output  1  SRAM chip enable, active-low
  WEN  output  1  SRAM write enable, active-low
  OEN  output  1  SRAM output enable, active-low
  A  output  ADDR_W  SRAM address
  Data2Mem  output  DATA_W  SRAM write data
  ReadDataMem  input  DATA_W  SRAM read data
REQ-003 SHALL have one clock and a synchronous active-low reset, rst_n, sampled only on the rising edge of clk.

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RDWAIT; all outputs registered.
REQ-005 In IDLE: req0/req1 sampled; if any high, winner's we/addr/wdata latched into command regs, next state ACCESS; else stay IDLE.
REQ-006 Arbitration SHALL be round-robin via 1-bit pointer prio: single request wins; simultaneous requests -> requester prio wins; after every grant prio <= index of the loser (the other requester).
REQ-007 In ACCESS (exactly one cycle): gnt of winner = 1, CEN = 0, A = latched addr, WEN = ~we, OEN = we, Data2Mem = latched wdata on writes, 0 on reads.
REQ-008 From ACCESS: write -> IDLE; read -> RDWAIT with latency counter loaded to READ_LAT.
REQ-009 In RDWAIT: CEN = WEN = OEN = 1; counter decrements each cycle; on the edge where it reaches 0, ReadDataMem captured into winner's rdata, rvalid of winner = 1 for the next cycle, next state IDLE.
REQ-010 Requests SHALL be sampled only in IDLE; requester holds req/we/addr/wdata stable until it sees gnt and deasserts req the cycle after gnt; req high in IDLE after a grant counts as a new request.
REQ-011 Outside ACCESS: CEN = WEN = OEN = 1, A and Data2Mem hold last value; gnt0 = gnt1 = 0.
REQ-012 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together; at most one SRAM access in flight.
REQ-013 Throughput: write = 2 cycles (IDLE+ACCESS), read = 2+READ_LAT cycles from sampling to return to IDLE; rvalid coincides with the IDLE cycle.
REQ-014 Address and data SHALL pass unmodified at full width; no wrap or range checking.

Reset
REQ-015 While rst_n = 0 at a rising edge: state = IDLE, prio = 0, counter = 0, CEN = WEN = OEN = 1, A = 0, Data2Mem = 0, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
REQ-016 Reset in ACCESS or RDWAIT SHALL abort the access; no gnt/rvalid for it after reset release; requests re-arbitrated from IDLE with prio = 0.

Verification
REQ-017 Write: req0=1, we0=1, addr0=0x05, wdata0=0xDEADBEEF in IDLE -> next cycle gnt0=1, CEN=0, WEN=0, OEN=1, A=0x05, Data2Mem=0xDEADBEEF, one cycle only; then IDLE.
REQ-018 Read-back: READ_LAT=1, SRAM model holding 0xDEADBEEF at 0x05, req1=1, we1=0, addr1=0x05 -> gnt1 in ACCESS with CEN=0, OEN=0, WEN=1; rvalid1=1 and rdata1=0xDEADBEEF exactly 3 cycles after sampling edge.
REQ-019 Contention: after reset req0 and req1 held high continuously with writes -> grants alternate gnt0, gnt1, gnt0, gnt1; first grant gnt0.
REQ-020 Priority toggle: req1 alone granted, then req0 and req1 simultaneous -> gnt0 first.
REQ-021 Reset mid-read: rst_n=0 during RDWAIT -> next cycle all strobes 1, rvalid0=rvalid1=0, rdata regs 0; no late rvalid after release.
REQ-022 READ_LAT=3 read -> strobe one cycle, 3 RDWAIT cycles, rvalid 5 cycles after sampling edge, no other SRAM strobes meanwhile.
